// File: rtl/solix_pkg.sv
// solix_pkg: opcodes, flag indices and FSM state shared by the ALU sequencer and its bench
package solix_pkg;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NOT  = 3'b101;
    localparam logic [2:0] ALU_SHL1 = 3'b110;
    localparam logic [2:0] ALU_SHR1 = 3'b111;

    localparam logic [3:0] OP_SHLN = 4'b1000;
    localparam logic [3:0] OP_SHRN = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    function automatic logic [3:0] pack_flags(input logic z, input logic n, input logic c, input logic o);
        logic [3:0] f;
        f = 4'b0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_O] = o;
        return f;
    endfunction
endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs single ALU ops, multi-cycle shifts and a shift-add multiply on an external ALU
module alu_sequencer
    import solix_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_carry,
    input  logic        alu_overflow
);
    state_t state, state_nx;
    logic        live;
    logic [3:0]  op;
    logic [15:0] opa, opb, res, mul_acc;
    logic [4:0]  cnt;
    logic [3:0]  flags;
    logic        err;
    logic        is_single, is_shift, is_mul, zero_n, accept, shift_in;

    assign is_single  = ~op[3];
    assign is_shift   = op == OP_SHLN || op == OP_SHRN;
    assign is_mul     = op == OP_MUL;
    assign zero_n     = opb[3:0] == 4'd0;
    assign cmd_ready  = state == IDLE && live;
    assign rsp_valid  = state == DONE;
    assign rsp_result = res;
    assign rsp_flags  = flags;
    assign rsp_err    = err;
    assign accept     = cmd_valid && cmd_ready;
    assign shift_in   = cmd_op == OP_SHLN || cmd_op == OP_SHRN;
    assign mul_acc    = opb[0] ? alu_result : res;

    always_comb begin
        state_nx = state;
        alu_a    = 16'h0;
        alu_b    = 16'h0;
        alu_op   = ALU_ADD;
        if (state == IDLE && accept) state_nx = EXEC;
        else if (state == EXEC && cnt == 5'd0) state_nx = DONE;
        else if (state == DONE && rsp_ready) state_nx = IDLE;
        if (state == EXEC) begin
            alu_a  = is_single ? opa : res;
            alu_b  = is_single ? opb : is_mul ? opa : 16'h0;
            alu_op = is_single ? op[2:0] :
                     is_shift ? (zero_n ? ALU_OR : op == OP_SHLN ? ALU_SHL1 : ALU_SHR1) : ALU_ADD;
        end
    end

    // res doubles as the shift working register and the multiply accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
            op    <= 4'h0;
            opa   <= 16'h0;
            opb   <= 16'h0;
            res   <= 16'h0;
            cnt   <= 5'd0;
            flags <= 4'h0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (state == IDLE && accept) begin
                op    <= cmd_op;
                opa   <= cmd_a;
                opb   <= cmd_b;
                err   <= cmd_op > OP_MUL;
                flags <= 4'h0;
                res   <= shift_in ? cmd_a : 16'h0;
                cnt   <= cmd_op == OP_MUL ? 5'd15 :
                         (shift_in && cmd_b[3:0] != 4'd0) ? {1'b0, cmd_b[3:0]} - 5'd1 : 5'd0;
            end else if (state == EXEC) begin
                cnt <= cnt == 5'd0 ? 5'd0 : cnt - 5'd1;
                if (is_single || is_shift) begin
                    res   <= alu_result;
                    flags <= pack_flags(alu_zero, alu_negative,
                                        alu_carry && !(is_shift && zero_n),
                                        alu_overflow && !(is_shift && zero_n));
                end else if (is_mul) begin
                    opa   <= opa << 1;
                    opb   <= opb >> 1;
                    res   <= mul_acc;
                    flags <= pack_flags(mul_acc == 16'h0, mul_acc[15], 1'b0, 1'b0);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed scoreboard bench with a behavioural ALU attached to the alu_* ports
module tb_alu_sequencer;
    import solix_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [3:0]  cmd_op, rsp_flags;
    logic [15:0] cmd_a, cmd_b, rsp_result, alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_zero, alu_negative, alu_carry, alu_overflow;

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_negative(alu_negative), .alu_carry(alu_carry), .alu_overflow(alu_overflow)
    );

    // Reference ALU: C is carry-out for ADD, borrow for SUB, the bit shifted out for SHL1/SHR1
    always_comb begin
        logic [16:0] s;
        s = 17'h0;
        alu_carry = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                alu_carry = s[16];
                alu_overflow = alu_a[15] == alu_b[15] && s[15] != alu_a[15];
            end
            ALU_SUB: begin
                s = {1'b0, alu_a} - {1'b0, alu_b};
                alu_carry = alu_a < alu_b;
                alu_overflow = alu_a[15] != alu_b[15] && s[15] != alu_a[15];
            end
            ALU_AND:  s = {1'b0, alu_a & alu_b};
            ALU_OR:   s = {1'b0, alu_a | alu_b};
            ALU_XOR:  s = {1'b0, alu_a ^ alu_b};
            ALU_NOT:  s = {1'b0, ~alu_a};
            ALU_SHL1: begin s = {1'b0, alu_a << 1}; alu_carry = alu_a[15]; end
            default:  begin s = {1'b0, alu_a >> 1}; alu_carry = alu_a[0]; end
        endcase
        alu_result = s[15:0];
        alu_zero = s[15:0] == 16'h0;
        alu_negative = s[15];
    end

    function automatic exp_t ref_exp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [16:0] s;
        logic [31:0] p;
        logic c, o;
        int n;
        n = int'(b[3:0]);
        c = 1'b0;
        o = 1'b0;
        e.e = 1'b0;
        e.lat = 1;
        e.r = 16'h0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; e.r = s[15:0]; c = s[16]; o = a[15] == b[15] && s[15] != a[15]; end
            4'd1: begin e.r = a - b; c = a < b; o = a[15] != b[15] && e.r[15] != a[15]; end
            4'd2: e.r = a & b;
            4'd3: e.r = a | b;
            4'd4: e.r = a ^ b;
            4'd5: e.r = ~a;
            4'd6: begin e.r = a << 1; c = a[15]; end
            4'd7: begin e.r = a >> 1; c = a[0]; end
            4'd8: begin e.r = a << n; c = n > 0 ? a[16 - n] : 1'b0; e.lat = n > 0 ? n : 1; end
            4'd9: begin e.r = a >> n; c = n > 0 ? a[n - 1] : 1'b0; e.lat = n > 0 ? n : 1; end
            4'd10: begin p = {16'h0, a} * {16'h0, b}; e.r = p[15:0]; e.lat = 16; end
            default: begin e.e = 1'b1; e.f = 4'h0; return e; end
        endcase
        e.f = {e.r == 16'h0, e.r[15], c, o};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic [3:0] f, input logic e, input int lat);
        exp_t x;
        x.r = r; x.f = f; x.e = e; x.lat = lat;
        return x;
    endfunction

    task automatic do_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input string tag);
        exp_t e;
        int lat;
        logic [15:0] r0;
        logic [3:0] f0;
        @(negedge clk);
        chk({tag, ".idle_alu"}, {alu_a, alu_b, 1'b0, alu_op}, 64'h0);
        chk({tag, ".ready"}, cmd_ready, 1);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (op < 4'd8) chk({tag, ".alu_drive"}, {alu_a, alu_b, 1'b0, alu_op}, {a, b, 1'b0, op[2:0]});
        cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = ~a; cmd_b = ~b;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, ".latency"}, lat, e.lat);
        if (!rsp_valid) return;
        chk({tag, ".result"}, rsp_result, e.r);
        chk({tag, ".flags"}, rsp_flags, e.f);
        chk({tag, ".err"}, rsp_err, e.e);
        r0 = rsp_result;
        f0 = rsp_flags;
        repeat (hold) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 16'h1234; cmd_b = 16'h1111;
            @(posedge clk); #1;
            chk({tag, ".hold_out"}, {rsp_valid, cmd_ready, rsp_err, r0, f0}, {1'b1, 1'b0, e.e, rsp_result, rsp_flags});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".handshake"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        exp_t e;
        bit seen;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 4'h0; cmd_a = 16'h0; cmd_b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {cmd_ready, rsp_valid, rsp_err, rsp_result, rsp_flags, alu_a, alu_b, alu_op}, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", cmd_ready, 1);

        sb.push_back(mk(16'h8000, 4'b0101, 1'b0, 1));  do_cmd(4'b0000, 16'h7FFF, 16'h0001, 0, "add");
        sb.push_back(mk(16'h0010, 4'b0000, 1'b0, 4));  do_cmd(4'b1000, 16'h0001, 16'h0004, 0, "shln4");
        sb.push_back(mk(16'h0000, 4'b1010, 1'b0, 2));  do_cmd(4'b1001, 16'h0003, 16'h0002, 0, "shrn2");
        sb.push_back(mk(16'h8421, 4'b0100, 1'b0, 1));  do_cmd(4'b1001, 16'h8421, 16'h0000, 0, "shrn0");
        sb.push_back(mk(16'h000F, 4'b0000, 1'b0, 16)); do_cmd(4'b1010, 16'h0003, 16'h0005, 0, "mul3x5");
        sb.push_back(mk(16'h0000, 4'b1000, 1'b0, 16)); do_cmd(4'b1010, 16'h0100, 16'h0100, 0, "mul_ovf");
        sb.push_back(mk(16'h0000, 4'b0000, 1'b1, 1));  do_cmd(4'b1101, 16'hABCD, 16'h1234, 0, "reserved");

        sb.push_back(ref_exp(4'd1, 16'h0005, 16'h0007)); do_cmd(4'd1, 16'h0005, 16'h0007, 0, "sub");
        sb.push_back(ref_exp(4'd4, 16'hF0F0, 16'h0FF0)); do_cmd(4'd4, 16'hF0F0, 16'h0FF0, 0, "xor");
        sb.push_back(ref_exp(4'd5, 16'h00FF, 16'h0000)); do_cmd(4'd5, 16'h00FF, 16'h0000, 0, "not");
        sb.push_back(ref_exp(4'd6, 16'h8001, 16'h0000)); do_cmd(4'd6, 16'h8001, 16'h0000, 0, "shl1");
        sb.push_back(ref_exp(4'd7, 16'h0003, 16'h0000)); do_cmd(4'd7, 16'h0003, 16'h0000, 0, "shr1");
        sb.push_back(ref_exp(4'd2, 16'hFF00, 16'h0F0F)); do_cmd(4'd2, 16'hFF00, 16'h0F0F, 0, "and");
        sb.push_back(ref_exp(4'd8, 16'h1234, 16'h000F)); do_cmd(4'd8, 16'h1234, 16'h000F, 0, "shln15");
        sb.push_back(ref_exp(4'd8, 16'h4321, 16'h0000)); do_cmd(4'd8, 16'h4321, 16'h0000, 0, "shln0");
        sb.push_back(ref_exp(4'd10, 16'h1234, 16'h0ABC)); do_cmd(4'd10, 16'h1234, 16'h0ABC, 3, "mul_bp");
        for (int i = 0; i < 4; i++) begin
            logic [3:0] op;
            logic [15:0] a, b;
            op = 4'($urandom_range(0, 10));
            a = 16'($urandom);
            b = 16'($urandom);
            sb.push_back(ref_exp(op, a, b));
            do_cmd(op, a, b, i, $sformatf("rand%0d_op%0d", i, op));
        end

        @(negedge clk);
        cmd_op = 4'b1010; cmd_a = 16'h0003; cmd_b = 16'h0005; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_mul_reset", {cmd_ready, rsp_valid, rsp_err, rsp_result, rsp_flags, alu_a, alu_b, alu_op}, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_abort", cmd_ready, 1);
        seen = 1'b0;
        repeat (24) begin
            @(posedge clk); #1;
            seen |= rsp_valid;
        end
        chk("no_rsp_after_abort", seen, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
